filter3x3_mac_sched: RTL and testbench
======================================

// Module: filter3x3_mac_sched
// PURPOSE
//  Sequences one 3x3 filter window through a single shared qmults multiplier: 9 pixel*coef taps
//  issued back to back, signed-magnitude products accumulated, result rounded and clamped to 8 bits.
//  Sits between the window line-buffer (upstream) and pixel output stage (downstream) in avalon_filter_3x3.
// PARAMETERS
//  FP_WORD_LENGTH  32  coef/product word width, signed-magnitude (MSB = sign); must match qmults
//  FP_FRAC_LENGTH  15  fractional bits of coef/product; must match qmults
//  MULT_LAT        8   enabled cycles from tap issue to product on mult_y (qmults depth)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  in_valid    in   1       window + coefs present
//  in_ready    out  1       window accepted when in_valid & in_ready
//  pix_win     in   72      9 unsigned pixels, tap k = [8k+7:8k], k=0 top-left, row-major
//  coef_win    in   9*W     9 coefs, tap k = [W*k+W-1:W*k], W=FP_WORD_LENGTH
//  mult_a      out  8       pixel to qmults a
//  mult_b      out  W       coef to qmults b
//  mult_valid  out  1       qmults valid (acts as its pipeline enable)
//  mult_y      in   W       qmults y, signed-magnitude product
//  out_valid   out  1       pix_out valid
//  out_ready   in   1       downstream accepts when out_valid & out_ready
//  pix_out     out  8       filtered pixel
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, pix_out=0, mult_valid=0, mult_a=0, mult_b=0, busy=0,
//   acc=0, counters=0. Reset mid-job aborts it; no output produced for that window.
//  States: IDLE -> RUN -> OUT -> IDLE.
//  IDLE: in_ready=1. On accept (cycle T) latch pix_win/coef_win, clear acc, cyc=0, go RUN.
//  RUN: mult_valid=1 every cycle, cyc counts 0..MULT_LAT+8 (cycles T+1..T+17 for default).
//   cyc 0..8: drive tap k=cyc on mult_a/mult_b; cyc>8: mult_a=0, mult_b=0 (flush only).
//   cyc MULT_LAT..MULT_LAT+8: mult_y holds product of tap cyc-MULT_LAT; add it to acc.
//   After last add (cyc=MULT_LAT+8) go OUT; pix_out registered from final acc.
//  OUT: out_valid=1 from cycle T+18; mult_valid=0 (multiplier frozen); hold pix_out stable
//   until out_ready=1, then out_valid=0, go IDLE. in_ready=0 in RUN and OUT.
//  Latency accept->out_valid = MULT_LAT+10 cycles (18 default); max throughput 1 window/19 cycles.
//  Arithmetic: acc is two's complement, W+4 bits. Product term = sign ? -mag : +mag,
//   mag = mult_y[W-2:0]; negative zero (sign=1, mag=0) adds 0.
//   Final: if acc<0 -> 0; else r=(acc + 2^(FRAC-1)) >> FRAC; if r>255 -> 255; else r[7:0].
//  qmults has no reset: stale/X contents may sit in its pipeline. Only the MULT_LAT..MULT_LAT+8
//   samples of the current job are used; the first MULT_LAT enables flush stale data, so the
//   result never depends on prior aborted jobs.
//  in_valid while busy is ignored (not accepted); upstream holds it until in_ready.
//  out_ready while out_valid=0 has no effect.
// TESTING
//  1 Identity: coef[4]=0x00008000, others 0; pixels 1..9 -> pix_out=5, out_valid at T+18, exactly once.
//  2 Box: all coef 0x00000E39, all pixels 90 -> pix_out=90; all pixels 255 -> 255.
//  3 Negative/clamp: coef[0,3,6]=0x80008000, coef[2,5,8]=0x00008000; left col 200, right 10
//    -> 0; swap columns -> 255 (570 saturates).
//  4 Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid=1, pix_out stable, in_ready=0,
//    mult_valid=0; release -> IDLE next cycle, next window accepted.
//  5 Reset at T+10 of a job, then identity window (center 77) -> single output 77, no residue.
//  6 Negative zero: coef[4]=0x80000000, others 0x00000000, any pixels -> pix_out=0.

Source files
------------

// File: rtl/filter3x3_mac_sched.sv
// One 3x3 filter window per job, time-multiplexed through an external shared qmults multiplier.
// Nine taps are issued back to back, the signed-magnitude products are summed, then rounded and clamped to 8 bits.
module filter3x3_mac_sched #(
  parameter int FP_WORD_LENGTH = 32,
  parameter int FP_FRAC_LENGTH = 15,
  parameter int MULT_LAT       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [71:0]                   pix_win,
  input  logic [9*FP_WORD_LENGTH-1:0]   coef_win,
  output logic [7:0]                    mult_a,
  output logic [FP_WORD_LENGTH-1:0]     mult_b,
  output logic                          mult_valid,
  input  logic [FP_WORD_LENGTH-1:0]     mult_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    pix_out,
  output logic                          busy
);

  localparam int W     = FP_WORD_LENGTH;
  localparam int AW    = W + 4;
  localparam int CYC_W = $clog2(MULT_LAT + 9);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [CYC_W-1:0] CYC_LAST_TAP  = CYC_W'(8);
  localparam logic [CYC_W-1:0] CYC_FIRST_ADD = CYC_W'(MULT_LAT);
  localparam logic [CYC_W-1:0] CYC_LAST      = CYC_W'(MULT_LAT + 8);

  logic [1:0]         state_reg;
  logic [CYC_W-1:0]   cyc_reg;
  logic [AW-1:0]      acc_reg;
  logic [71:0]        pix_reg;
  logic [9*W-1:0]     coef_reg;
  logic [7:0]         pix_out_reg;

  logic [7:0]         pix_tap  [9];
  logic [W-1:0]       coef_tap [9];
  logic [3:0]         tap_idx;
  logic               issue_tap;

  logic [AW-1:0]      mag_ext;
  logic [AW-1:0]      term;
  logic [AW-1:0]      acc_sum;
  logic [AW-1:0]      rounded;
  logic [AW-1:0]      shifted;
  logic [7:0]         pix_next;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      assign pix_tap[gi]  = pix_reg[8*gi +: 8];
      assign coef_tap[gi] = coef_reg[W*gi +: W];
    end
  endgenerate

  assign tap_idx   = cyc_reg[3:0];
  assign issue_tap = (state_reg == S_RUN) && (cyc_reg <= CYC_LAST_TAP);

  // Past the ninth tap the multiplier is still clocked with zeros so earlier taps drain out.
  assign mult_valid = (state_reg == S_RUN);
  assign mult_a     = issue_tap ? pix_tap[tap_idx]  : 8'd0;
  assign mult_b     = issue_tap ? coef_tap[tap_idx] : '0;

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_OUT);
  assign busy      = (state_reg != S_IDLE);
  assign pix_out   = pix_out_reg;

  // Negative zero yields -0 == 0, so it needs no special case.
  assign mag_ext  = {{(AW-W+1){1'b0}}, mult_y[W-2:0]};
  assign term     = mult_y[W-1] ? (-mag_ext) : mag_ext;
  assign acc_sum  = acc_reg + term;
  assign rounded  = acc_sum + (AW'(1) << (FP_FRAC_LENGTH - 1));
  assign shifted  = rounded >> FP_FRAC_LENGTH;
  assign pix_next = acc_sum[AW-1]          ? 8'd0  :
                    (shifted > AW'(255))   ? 8'hFF : shifted[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cyc_reg     <= '0;
      acc_reg     <= '0;
      pix_reg     <= '0;
      coef_reg    <= '0;
      pix_out_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            pix_reg   <= pix_win;
            coef_reg  <= coef_win;
            acc_reg   <= '0;
            cyc_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          cyc_reg <= cyc_reg + 1'b1;
          if (cyc_reg >= CYC_FIRST_ADD) begin
            acc_reg <= acc_sum;
          end
          if (cyc_reg == CYC_LAST) begin
            pix_out_reg <= pix_next;
            state_reg   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter3x3_mac_sched.sv
// Directed bench for filter3x3_mac_sched with a behavioural qmults pipeline (no reset, enabled by mult_valid).
module tb_filter3x3_mac_sched;

  localparam int W   = 32;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   pix_win;
  logic [9*W-1:0] coef_win;
  logic [7:0]    mult_a;
  logic [W-1:0]  mult_b;
  logic          mult_valid;
  logic [W-1:0]  mult_y;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    pix_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  px [9];
  logic [31:0] cf [9];

  always #5 clk = ~clk;

  filter3x3_mac_sched #(.FP_WORD_LENGTH(W), .FP_FRAC_LENGTH(15), .MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pix_win(pix_win), .coef_win(coef_win), .mult_a(mult_a), .mult_b(mult_b),
    .mult_valid(mult_valid), .mult_y(mult_y), .out_valid(out_valid),
    .out_ready(out_ready), .pix_out(pix_out), .busy(busy)
  );

  // qmults stand-in: product = pixel * |coef| carrying the coef sign, LAT enabled stages deep.
  logic [W-1:0] pipe [LAT];
  logic [38:0]  raw_prod;
  assign raw_prod = mult_a * mult_b[W-2:0];
  assign mult_y   = pipe[LAT-1];

  always @(posedge clk) begin
    if (mult_valid) begin
      pipe[0] <= {mult_b[W-1], raw_prod[W-2:0]};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_px();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = px[k];
    return r;
  endfunction

  function automatic logic [9*W-1:0] pack_cf();
    logic [9*W-1:0] r;
    for (int k = 0; k < 9; k++) r[W*k +: W] = cf[k];
    return r;
  endfunction

  task automatic fill(input logic [7:0] p, input logic [31:0] c);
    for (int k = 0; k < 9; k++) begin
      px[k] = p;
      cf[k] = c;
    end
  endtask

  // Offers the current px/cf window, checks tap issue, latency, result and the single-beat output.
  task automatic run_window(input string tag, input logic [7:0] exp_pix, input int hold);
    int w;
    int lat;
    logic [7:0] exp_a;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    pix_win  = pack_px();
    coef_win = pack_cf();
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (!out_valid && lat <= 17) begin
        exp_a = (lat - 1 <= 8) ? px[lat-1] : 8'd0;
        chk($sformatf("%s_mult_a%0d", tag, lat - 1), 32'(mult_a), 32'(exp_a));
        chk($sformatf("%s_mult_valid%0d", tag, lat - 1), 32'(mult_valid), 32'd1);
      end
    end while (!out_valid && lat < 60);
    chk({tag, "_latency"}, 32'(lat), 32'd18);
    chk({tag, "_pix_out"}, 32'(pix_out), 32'(exp_pix));
    $display("window %s: pix_out=%0d expected=%0d latency=%0d", tag, pix_out, exp_pix, lat);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_pix"}, 32'(pix_out), 32'(exp_pix));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_mult_valid"}, 32'(mult_valid), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_once"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pix_win   = '0;
    coef_win  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pix_out", 32'(pix_out), 32'd0);
    chk("rst_mult_valid", 32'(mult_valid), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", mult_b, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Identity, pixels 1..9
    fill(8'd0, 32'h0);
    for (int k = 0; k < 9; k++) px[k] = 8'(k + 1);
    cf[4] = 32'h0000_8000;
    run_window("identity", 8'd5, 0);

    // Box filter
    fill(8'd90, 32'h0000_0E39);
    run_window("box90", 8'd90, 0);
    fill(8'd255, 32'h0000_0E39);
    run_window("box255", 8'd255, 0);

    // Negative result clamps low, large positive saturates
    fill(8'd123, 32'h0);
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) begin px[k] = 8'd200; cf[k] = 32'h8000_8000; end
      if (k % 3 == 2) begin px[k] = 8'd10;  cf[k] = 32'h0000_8000; end
    end
    run_window("neg_clamp", 8'd0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) px[k] = 8'd10;
      if (k % 3 == 2) px[k] = 8'd200;
    end
    run_window("sat", 8'd255, 0);

    // Rounding boundary: exactly one half rounds up, just below does not
    fill(8'd0, 32'h0);
    px[4] = 8'd1;
    cf[4] = 32'h0000_4000;
    run_window("round_half", 8'd1, 0);
    cf[4] = 32'h0000_3FFF;
    run_window("round_below", 8'd0, 0);

    // Backpressure for 5 cycles, then a window accepted right after release
    fill(8'd0, 32'h0);
    px[4] = 8'd42;
    cf[4] = 32'h0000_8000;
    out_ready = 1'b0;
    run_window("bp", 8'd42, 5);
    px[4] = 8'd43;
    run_window("after_bp", 8'd43, 0);

    // Reset during cycle T+10 of a job aborts it; next job is clean
    fill(8'd255, 32'h0000_7FFF);
    pix_win  = pack_px();
    coef_win = pack_cf();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_mult_valid", 32'(mult_valid), 32'd0);
    chk("abort_pix_out", 32'(pix_out), 32'd0);
    fill(8'd0, 32'h0);
    px[4] = 8'd77;
    cf[4] = 32'h0000_8000;
    run_window("post_reset", 8'd77, 0);

    // Negative zero contributes nothing
    fill(8'd200, 32'h0);
    cf[4] = 32'h8000_0000;
    run_window("negzero", 8'd0, 0);
    px[0] = 8'd3;
    cf[0] = 32'h0000_8000;
    run_window("negzero_plus", 8'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
